fp_shift_sched: RTL

//  Scheduler and sequencer for the shared iterative mantissa shifter in the FP32 adder datapath.
//  - Two clients: exponent ALIGN (right shift by exponent difference, with sticky) and result NORMALIZE (left shift until hidden bit set).
//  - Arbitrates them round-robin, runs the shift one bit per clock and returns result plus status with a req/done handshake.

---
 rtl/fp_shift_sched.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_shift_sched.sv
// fp_shift_sched
//    Sequencer for the shared mantissa shifter of the FP32 adder. Two clients
//    share it: ALIGN (right shift by exponent difference, collecting sticky)
//    and NORMALIZE (left shift until the hidden bit is set). Ties between the
//    two are broken round-robin; after reset ALIGN wins the first tie.
//
//    Build option: define FSC_BARREL_EN to resolve every job in a single
//    cycle (barrel shift + leading-zero count). Without it, the shift runs
//    one bit per clock. Results are identical in both builds.
//
//    Ports
//       clk_i, rst_n_i                    clock, async active-low reset
//       align_req_i/_data_i/_count_i      ALIGN level request and operands
//       align_done_o                      one-cycle result-valid pulse
//       align_result_o, align_sticky_o    shifted mantissa, OR of lost bits
//       norm_req_i/_data_i                NORMALIZE level request and operand
//       norm_done_o                       one-cycle result-valid pulse
//       norm_result_o, norm_shift_o       normalized mantissa, shifts applied
//       norm_zero_o                       operand was zero
//       busy_o                            a job is in progress
//
//    state | meaning
//    IDLE  | waiting for a request; grants and loads operands
//    SHIFT | iterative shift, one bit per clock
//    DONE  | result valid, done pulse for the served client
module fp_shift_sched #(
   parameter int WIDTH = 24,
   parameter int CNT_W = 8,
   parameter int SHW   = 5
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             align_req_i,
   input  logic [WIDTH-1:0] align_data_i,
   input  logic [CNT_W-1:0] align_count_i,
   output logic             align_done_o,
   output logic [WIDTH-1:0] align_result_o,
   output logic             align_sticky_o,
   input  logic             norm_req_i,
   input  logic [WIDTH-1:0] norm_data_i,
   output logic             norm_done_o,
   output logic [WIDTH-1:0] norm_result_o,
   output logic [SHW-1:0]   norm_shift_o,
   output logic             norm_zero_o,
   output logic             busy_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             serve_norm_q, serve_norm_d;
   logic             last_norm_q, last_norm_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sticky_q, sticky_d;
   logic [SHW-1:0]   nshift_q, nshift_d;
   logic [WIDTH-1:0] a_res_q, a_res_d;
   logic             a_sticky_q, a_sticky_d;
   logic [WIDTH-1:0] n_res_q, n_res_d;
   logic [SHW-1:0]   n_shift_q, n_shift_d;
   logic             n_zero_q, n_zero_d;
   logic             grant_norm;

   // NORM wins only when ALIGN is idle or ALIGN was the last one served.
   assign grant_norm = norm_req_i & (~align_req_i | ~last_norm_q);

`ifdef FSC_BARREL_EN
   logic [WIDTH-1:0] bar_res, bar_mask;
   logic             bar_sticky;
   logic [SHW-1:0]   bar_lzc;

   always_comb begin
      bar_res = align_data_i >> align_count_i;
      if (align_count_i >= CNT_W'(WIDTH)) bar_mask = '1;
      else                                bar_mask = ~({WIDTH{1'b1}} << align_count_i);
      bar_sticky = |(align_data_i & bar_mask);
      // ascending scan: the highest set bit is the last to write
      bar_lzc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (norm_data_i[i]) bar_lzc = SHW'(WIDTH - 1 - i);
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      serve_norm_d = serve_norm_q;
      last_norm_d  = last_norm_q;
      sh_d         = sh_q;
      cnt_d        = cnt_q;
      sticky_d     = sticky_q;
      nshift_d     = nshift_q;
      a_res_d      = a_res_q;
      a_sticky_d   = a_sticky_q;
      n_res_d      = n_res_q;
      n_shift_d    = n_shift_q;
      n_zero_d     = n_zero_q;
      case (state_q)
         IDLE: begin
            if (align_req_i | norm_req_i) begin
               serve_norm_d = grant_norm;
               last_norm_d  = grant_norm;
               if (grant_norm) begin
`ifdef FSC_BARREL_EN
                  state_d   = DONE;
                  n_res_d   = norm_data_i << bar_lzc;
                  n_shift_d = bar_lzc;
                  n_zero_d  = (norm_data_i == '0);
`else
                  n_zero_d = 1'b0;
                  if (norm_data_i == '0) begin
                     state_d   = DONE;
                     n_res_d   = '0;
                     n_shift_d = '0;
                     n_zero_d  = 1'b1;
                  end else if (norm_data_i[WIDTH-1]) begin
                     state_d   = DONE;
                     n_res_d   = norm_data_i;
                     n_shift_d = '0;
                  end else begin
                     state_d  = SHIFT;
                     sh_d     = norm_data_i;
                     nshift_d = '0;
                  end
`endif
               end else begin
`ifdef FSC_BARREL_EN
                  state_d    = DONE;
                  a_res_d    = bar_res;
                  a_sticky_d = bar_sticky;
`else
                  if (align_count_i == '0) begin
                     state_d    = DONE;
                     a_res_d    = align_data_i;
                     a_sticky_d = 1'b0;
                  end else if (align_count_i >= CNT_W'(WIDTH)) begin
                     state_d    = DONE;
                     a_res_d    = '0;
                     a_sticky_d = |align_data_i;
                  end else begin
                     state_d  = SHIFT;
                     sh_d     = align_data_i;
                     cnt_d    = align_count_i;
                     sticky_d = 1'b0;
                  end
`endif
               end
            end
         end
         SHIFT: begin
            if (serve_norm_q) begin
               sh_d     = sh_q << 1;
               nshift_d = nshift_q + SHW'(1);
               // bit WIDTH-2 becomes the hidden bit after this shift
               if (sh_q[WIDTH-2]) begin
                  state_d   = DONE;
                  n_res_d   = sh_q << 1;
                  n_shift_d = nshift_q + SHW'(1);
                  n_zero_d  = 1'b0;
               end
            end else begin
               sh_d     = sh_q >> 1;
               sticky_d = sticky_q | sh_q[0];
               cnt_d    = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d    = DONE;
                  a_res_d    = sh_q >> 1;
                  a_sticky_d = sticky_q | sh_q[0];
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         serve_norm_q <= 1'b0;
         last_norm_q  <= 1'b1;
         sh_q         <= '0;
         cnt_q        <= '0;
         sticky_q     <= 1'b0;
         nshift_q     <= '0;
         a_res_q      <= '0;
         a_sticky_q   <= 1'b0;
         n_res_q      <= '0;
         n_shift_q    <= '0;
         n_zero_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         serve_norm_q <= serve_norm_d;
         last_norm_q  <= last_norm_d;
         sh_q         <= sh_d;
         cnt_q        <= cnt_d;
         sticky_q     <= sticky_d;
         nshift_q     <= nshift_d;
         a_res_q      <= a_res_d;
         a_sticky_q   <= a_sticky_d;
         n_res_q      <= n_res_d;
         n_shift_q    <= n_shift_d;
         n_zero_q     <= n_zero_d;
      end
   end

   assign align_done_o   = (state_q == DONE) & ~serve_norm_q;
   assign norm_done_o    = (state_q == DONE) &  serve_norm_q;
   assign align_result_o = a_res_q;
   assign align_sticky_o = a_sticky_q;
   assign norm_result_o  = n_res_q;
   assign norm_shift_o   = n_shift_q;
   assign norm_zero_o    = n_zero_q;
   assign busy_o         = (state_q != IDLE);

endmodule
